// File: rtl/store_buffer_if.sv
// rtl/store_buffer_if.sv - pipeline and data-memory signals of the store buffer
interface store_buffer_if #(
    parameter int PC_BITS = 32
);
    logic               mem_write_m;
    logic               mem_read_m;
    logic [PC_BITS-1:0] alu_out_m;
    logic [PC_BITS-1:0] write_data_m;
    logic [PC_BITS-1:0] read_data_m;
    logic               stall_m;
    logic [PC_BITS-1:0] dm_addr;
    logic [PC_BITS-1:0] dm_wdata;
    logic               dm_we;
    logic [PC_BITS-1:0] dm_rdata;
    logic               sb_empty;

    modport slave (
        input  mem_write_m, mem_read_m, alu_out_m, write_data_m, dm_rdata,
        output read_data_m, stall_m, dm_addr, dm_wdata, dm_we, sb_empty
    );

    modport master (
        output mem_write_m, mem_read_m, alu_out_m, write_data_m, dm_rdata,
        input  read_data_m, stall_m, dm_addr, dm_wdata, dm_we, sb_empty
    );
endinterface

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - posted-write FIFO in front of the data memory port
// STORE_FWD_EN selects load forwarding; otherwise matching loads stall until drained.
module store_buffer #(
    parameter int PC_BITS = 32,
    parameter int DEPTH   = 4
) (
    input  logic           clk,
    input  logic           rst,
    store_buffer_if.slave  sb
);
    localparam int LOG = $clog2(DEPTH);

    logic [PC_BITS-1:0] addr_q [DEPTH];
    logic [PC_BITS-1:0] data_q [DEPTH];
    logic [LOG-1:0]     head_q, head_d;
    logic [LOG-1:0]     tail_q, tail_d;
    logic [LOG:0]       count_q, count_d;

    logic full, hit, drain, enq, load_block;

    assign full = (count_q == (LOG+1)'(DEPTH));
    assign enq  = sb.mem_write_m && !full;

`ifdef STORE_FWD_EN
    logic [PC_BITS-1:0] fwd_data;

    // Walk oldest to youngest so the last match (closest to tail) wins.
    always_comb begin
        hit      = 1'b0;
        fwd_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (((LOG+1)'(k) < count_q) && (addr_q[head_q + LOG'(k)] == sb.alu_out_m)) begin
                hit      = 1'b1;
                fwd_data = data_q[head_q + LOG'(k)];
            end
        end
    end

    assign load_block     = 1'b0;
    assign sb.read_data_m = hit ? fwd_data : sb.dm_rdata;
`else
    always_comb begin
        hit = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (((LOG+1)'(k) < count_q) && (addr_q[head_q + LOG'(k)] == sb.alu_out_m)) begin
                hit = 1'b1;
            end
        end
    end

    // A load hitting a pending store gives the port to the drain instead.
    assign load_block     = sb.mem_read_m && hit;
    assign sb.read_data_m = sb.dm_rdata;
`endif

    assign drain       = (count_q != '0) && (!sb.mem_read_m || load_block);
    assign sb.stall_m  = (sb.mem_write_m && full) || load_block;
    assign sb.sb_empty = (count_q == '0);

    always_comb begin
        sb.dm_we    = 1'b0;
        sb.dm_addr  = sb.alu_out_m;
        sb.dm_wdata = '0;
        if (drain) begin
            sb.dm_we    = 1'b1;
            sb.dm_addr  = addr_q[head_q];
            sb.dm_wdata = data_q[head_q];
        end
    end

    always_comb begin
        head_d  = drain ? head_q + LOG'(1) : head_q;
        tail_d  = enq ? tail_q + LOG'(1) : tail_q;
        count_d = count_q;
        case ({enq, drain})
            2'b10:   count_d = count_q + (LOG+1)'(1);
            2'b01:   count_d = count_q - (LOG+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (enq) begin
                addr_q[tail_q] <= sb.alu_out_m;
                data_q[tail_q] <= sb.write_data_m;
            end
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - randomized store buffer bench against a queue-based reference
module tb_store_buffer;
    localparam int PC_BITS = 32;
    localparam int DEPTH   = 4;

    logic clk = 1'b0;
    logic rst;
    logic mem_clr;
    always #5 clk = ~clk;

    store_buffer_if #(.PC_BITS(PC_BITS)) sb();
    store_buffer #(.PC_BITS(PC_BITS), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .sb(sb));

    logic [31:0] dut_mem [16];
    logic [31:0] ref_mem [16];

    assign sb.dm_rdata = dut_mem[sb.dm_addr[3:0]];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 16; i++) dut_mem[i] <= '0;
        end else if (sb.dm_we) begin
            dut_mem[sb.dm_addr[3:0]] <= sb.dm_wdata;
        end
    end

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } ent_t;
    ent_t q[$];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d);
        int          cnt;
        bit          hit;
        bit          blk;
        bit          drn;
        logic [31:0] yd;
        @(negedge clk);
        sb.mem_write_m  = wr;
        sb.mem_read_m   = rd;
        sb.alu_out_m    = a;
        sb.write_data_m = d;
        #1;
        cnt = q.size();
        hit = 0;
        yd  = '0;
        foreach (q[i]) if (q[i].addr == a) begin
            hit = 1;
            yd  = q[i].data;
        end
`ifdef STORE_FWD_EN
        blk = 0;
`else
        blk = rd && hit;
`endif
        drn = (cnt > 0) && (!rd || blk);
        chk("stall", sb.stall_m, (wr && cnt == DEPTH) || blk);
        chk("empty", sb.sb_empty, cnt == 0);
        chk("dm_we", sb.dm_we, drn);
        if (drn) begin
            chk("drain_addr", sb.dm_addr, q[0].addr);
            chk("drain_wdata", sb.dm_wdata, q[0].data);
        end else begin
            chk("dm_addr", sb.dm_addr, a);
            chk("dm_wdata", sb.dm_wdata, '0);
        end
        if (rd && !blk) chk("rdata", sb.read_data_m, hit ? yd : ref_mem[a[3:0]]);
        if (drn) begin
            ref_mem[q[0].addr[3:0]] = q[0].data;
            void'(q.pop_front());
        end
        if (wr && cnt < DEPTH) q.push_back('{addr: a, data: d});
    endtask

    task automatic do_reset();
        @(negedge clk);
        sb.mem_write_m = 0;
        sb.mem_read_m  = 0;
        sb.alu_out_m   = '0;
        rst = 1'b1;
        #1;
        chk("rst_empty", sb.sb_empty, 1'b1);
        chk("rst_we", sb.dm_we, 1'b0);
        chk("rst_stall", sb.stall_m, 1'b0);
        chk("rst_rdata", sb.read_data_m, ref_mem[0]);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic mem_compare(input string tag);
        for (int i = 0; i < 16; i++) chk(tag, dut_mem[i], ref_mem[i]);
    endtask

    task automatic drain_all();
        for (int i = 0; i < DEPTH + 2; i++) step(0, 0, 32'd0, 32'd0);
        chk("drained_empty", sb.sb_empty, 1'b1);
    endtask

    initial begin
        int r;
        sb.mem_write_m  = 0;
        sb.mem_read_m   = 0;
        sb.alu_out_m    = '0;
        sb.write_data_m = '0;
        rst     = 1'b1;
        mem_clr = 1'b1;
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        @(negedge clk);
        @(negedge clk);
        mem_clr = 1'b0;
        do_reset();

        step(1, 0, 32'd5, 32'hAA);
        step(0, 0, 32'd0, 32'd0);
        step(0, 0, 32'd0, 32'd0);
        chk("mem5", dut_mem[5], 32'hAA);

        for (int i = 1; i <= 4; i++) step(1, 0, i, 32'h100 + i);
        step(1, 0, 32'd6, 32'h106);
        drain_all();

        step(1, 0, 32'd8, 32'h11);
        step(1, 0, 32'd8, 32'h22);
        step(0, 1, 32'd8, 32'd0);
        step(0, 1, 32'd8, 32'd0);
        drain_all();
        chk("mem8", dut_mem[8], 32'h22);

        step(1, 0, 32'd10, 32'h77);
        step(0, 1, 32'd9, 32'd0);
        step(1, 0, 32'd11, 32'h88);
        do_reset();
        drain_all();

        step(1, 0, 32'd3, 32'h5);
        step(0, 1, 32'd3, 32'd0);
        step(0, 1, 32'd3, 32'd0);
        drain_all();
        mem_compare("mem_directed");

        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                r = $urandom_range(0, 9);
                if (r < 5)      step(1, 0, $urandom_range(0, 7), $urandom);
                else if (r < 8) step(0, 1, $urandom_range(0, 7), 32'd0);
                else            step(0, 0, $urandom_range(0, 15), 32'd0);
            end
        end
        drain_all();
        mem_compare("mem_final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
